core_pipe_fetch_pf: RTL and testbench
=====================================

Name: core_pipe_fetch_pf

Overview:
- Parametrised successor fetch stage with a prefetch buffer.
- Decoupled instruction-memory protocol: request/grant address phase, separate in-order response phase, up to MAX_OUTSTANDING requests in flight.
- Configurable fetch width, buffer capacity and PC width. Stale responses are discarded after a control-flow change.
- Sits between the control-flow change bus / imem port and the decode stage. Presents 16- and 32-bit instructions with their PC.

Parameters:
XLEN, 64, PC and address width in bits.
FETCH_BYTES, 8, bytes per memory beat (4 or 8).
BUF_BYTES, 16, prefetch buffer capacity in bytes (even, ≥ FETCH_BYTES+4).
MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests (1..4).
PC_RESET_ADDRESS, 64'h80000000, PC after reset.

Ports:
g_clk  in  1  single clock; all state on rising edge
g_resetn  in  1  asynchronous active-low reset
cf_valid  in  1  control flow change request
cf_ack  out  1  change accepted this cycle
cf_target  in  XLEN  change destination; bit 0 ignored, treated as 0
imem_req  out  1  memory request valid
imem_addr  out  XLEN  request address, FETCH_BYTES-aligned
imem_gnt  in  1  request accepted
imem_rsp_valid  in  1  response beat valid, in request order
imem_rsp_err  in  1  response bus error
imem_rsp_rdata  in  8*FETCH_BYTES  response data, little-endian
s1_valid  out  1  instruction valid to decode
s1_instr  out  32  buffer head; upper half is don't-care for a 16-bit instruction
s1_pc  out  XLEN  PC of s1_instr
s1_ferr  out  2  error tag per halfword of s1_instr
s2_eat_2  in  1  decode consumes 2 bytes
s2_eat_4  in  1  decode consumes 4 bytes

Behaviour:
- Reset (async assert, sync release):
  - imem_req=0; imem_addr=PC_RESET_ADDRESS aligned down.
  - Buffer empty; s1_valid=0; s1_pc=PC_RESET_ADDRESS.
  - outstanding=0; drop_cnt=0; skip=PC_RESET_ADDRESS mod FETCH_BYTES.
- Reset asserted mid-transaction abandons all in-flight beats. Environment must not deliver responses for pre-reset requests.
- cf_ack = !imem_req || imem_gnt (combinational). The event is cf_valid && cf_ack.
- On a cf event, next cycle:
  - Buffer flushed; s1_pc=target.
  - imem_addr=target aligned down; skip=target mod FETCH_BYTES.
  - drop_cnt = outstanding (+1 if a grant occurred this cycle, −1 if a live response retired this cycle).
- cf event has priority over a same-cycle eat or response. A same-cycle response is discarded.
- Address phase:
  - imem_req and imem_addr are registered.
  - While imem_req && !imem_gnt, imem_addr and imem_req are held stable.
  - On grant, imem_addr advances by FETCH_BYTES.
- Issue rule for the next cycle: outstanding < MAX_OUTSTANDING and free_bytes ≥ FETCH_BYTES × (live_outstanding + 1 + granted_this_cycle).
  - live_outstanding = outstanding − drop_cnt.
  - This guarantees the buffer never overflows.
- outstanding increments on grant and decrements on rsp_valid. Both in one cycle leaves it unchanged.
- Response with drop_cnt > 0: discarded, drop_cnt decrements.
- Response with drop_cnt = 0:
  - Appends bytes [skip .. FETCH_BYTES−1] to the buffer tail; skip then clears to 0.
  - Every appended halfword is tagged with rsp_err.
- Buffer:
  - Halfword-granular shift queue; depth counter in bytes, width clog2(BUF_BYTES+1).
  - Append and drain may occur in the same cycle. Drain is applied before append in index computation.
- s1_valid = (depth ≥ 2 && head[1:0] != 2'b11) || (depth ≥ 4 && head[1:0] == 2'b11).
- s1_ferr = {tag[1], tag[0]}.
  - An error beat yields s1_valid with an error tag so decode can trap.
  - An erroneous 16-bit head is valid with depth ≥ 2 regardless of the next halfword.
- Drain:
  - eat_2 or eat_4 is honoured only when s1_valid; s1_pc increments by 2 or 4, wrapping modulo 2^XLEN.
  - eat_4 with depth < 4 is illegal; assert it.
  - Both eats high together is illegal; assert it.
- rsp_valid with outstanding = 0 is illegal; assert it.

Optional Feature:
- Macro CORE_FETCH_ERR_STOP_EN.
- Defined:
  - After accepting a live response with imem_rsp_err=1, no new requests are issued until the next cf event.
  - In-flight requests complete normally; imem_req drops once its pending request is granted.
- Undefined: fetching continues sequentially past error beats.

Test Plan:
- Reset release, FETCH_BYTES=8, constant-latency-1 memory returning 32-bit instrs at 0x80000000.. -> first imem_req cycle 1 after release, addr 0x80000000; s1_valid with s1_pc=0x80000000; sequential PCs step 4; depth never exceeds 16.
- cf_target=0x80000106 while 2 requests outstanding -> both stale beats dropped; next imem_addr=0x80000100; first s1_instr = bytes 6..7 of beat (16-bit) or bytes 6..9 across two beats (32-bit); s1_pc=0x80000106.
- Grant withheld 5 cycles with cf_valid high -> cf_ack=0 and imem_addr stable all 5 cycles; cf_ack=1 in the grant cycle; granted beat later dropped.
- Mixed 16/32-bit stream, with a 32-bit instr at offset 6 straddling beats -> s1_valid only after the second beat arrives; s1_instr assembled correctly; PCs 0x..6 then 0x..A.
- Decode stalled (no eats), memory latency 3, MAX_OUTSTANDING=2 -> issue stops when free bytes < 8×(live+1); no overflow; outstanding ≤ 2.
- rsp_err on beat 2 with CORE_FETCH_ERR_STOP_EN -> s1_ferr=2'b11 on the instr from that beat; no further imem_req until a cf event; without the macro, requests continue.

Source files
------------

// File: rtl/core_pipe_fetch_pf_if.sv
// Instruction-memory port of the fetch stage: request/grant address phase
// plus an in-order response phase.
interface core_pipe_fetch_pf_if #(
    parameter int XLEN        = 64,
    parameter int FETCH_BYTES = 8
);
    logic                     imem_req;
    logic [XLEN-1:0]          imem_addr;
    logic                     imem_gnt;
    logic                     imem_rsp_valid;
    logic                     imem_rsp_err;
    logic [8*FETCH_BYTES-1:0] imem_rsp_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rsp_valid, imem_rsp_err, imem_rsp_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rsp_valid, imem_rsp_err, imem_rsp_rdata
    );
endinterface

// File: rtl/core_pipe_fetch_pf.sv
// Fetch stage with a halfword-granular prefetch buffer.
// Optional feature: define CORE_FETCH_ERR_STOP_EN to stop issuing new
// requests after a live error beat, until the next control-flow change.
module core_pipe_fetch_pf #(
    parameter int              XLEN             = 64,
    parameter int              FETCH_BYTES      = 8,
    parameter int              BUF_BYTES        = 16,
    parameter int              MAX_OUTSTANDING  = 2,
    parameter logic [XLEN-1:0] PC_RESET_ADDRESS = XLEN'(64'h8000_0000)
) (
    input  logic                        g_clk,
    input  logic                        g_resetn,
    input  logic                        cf_valid,
    output logic                        cf_ack,
    input  logic [XLEN-1:0]             cf_target,
    core_pipe_fetch_pf_if.master        imem,
    output logic                        s1_valid,
    output logic [31:0]                 s1_instr,
    output logic [XLEN-1:0]             s1_pc,
    output logic [1:0]                  s1_ferr,
    input  logic                        s2_eat_2,
    input  logic                        s2_eat_4
);
    localparam int NH  = BUF_BYTES / 2;
    localparam int FH  = FETCH_BYTES / 2;
    localparam int DW  = $clog2(BUF_BYTES + 1);
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW  = $clog2(FETCH_BYTES);
    localparam int HIW = $clog2(NH);
    localparam logic [XLEN-1:0] ADDR_MASK  = ~XLEN'(FETCH_BYTES - 1);
    localparam logic [SW-1:0]   RESET_SKIP = PC_RESET_ADDRESS[SW-1:0] & ~SW'(1);

    logic [15:0]     buf_hw  [NH];
    logic [15:0]     buf_nxt [NH];
    logic [NH-1:0]   buf_tag, tag_nxt;
    logic [DW-1:0]   depth, depth_nxt, base_b, free_b, eat_bytes;
    logic [OW-1:0]   outstanding, drop_cnt, os_nxt, live;
    logic [SW-1:0]   skip;
    logic            cf_evt, granted, append, issue_ok, is32, stop_now;

    assign is32     = (buf_hw[0][1:0] == 2'b11);
    // An error-tagged head is presented as soon as its own halfword exists,
    // so decode can trap even if the rest of the instruction never arrives.
    assign s1_valid = ((depth >= DW'(2)) && (!is32 || buf_tag[0])) ||
                      ((depth >= DW'(4)) && is32);
    assign s1_instr = {buf_hw[1], buf_hw[0]};
    assign s1_ferr  = {buf_tag[1], buf_tag[0]};

    assign cf_ack    = !imem.imem_req || imem.imem_gnt;
    assign cf_evt    = cf_valid && cf_ack;
    assign granted   = imem.imem_req && imem.imem_gnt;
    assign append    = imem.imem_rsp_valid && (drop_cnt == '0) && !cf_evt;
    assign eat_bytes = !s1_valid ? DW'(0) : s2_eat_4 ? DW'(4) : s2_eat_2 ? DW'(2) : DW'(0);
    assign os_nxt    = outstanding + OW'(granted) - OW'(imem.imem_rsp_valid);
    assign live      = outstanding - drop_cnt;
    assign free_b    = DW'(BUF_BYTES) - depth;
    assign base_b    = depth - eat_bytes;

`ifdef CORE_FETCH_ERR_STOP_EN
    logic err_stop;
    assign stop_now = err_stop || (append && imem.imem_rsp_err);

    // Latch the error stop on a live error beat; a redirect clears it.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)                      err_stop <= 1'b0;
        else if (cf_evt)                    err_stop <= 1'b0;
        else if (append && imem.imem_rsp_err) err_stop <= 1'b1;
    end
`else
    assign stop_now = 1'b0;
`endif

    // Space is reserved for every live request plus the one about to issue,
    // so a granted beat always fits when it returns.
    assign issue_ok = (int'(os_nxt) < MAX_OUTSTANDING) &&
                      (int'(free_b) >= FETCH_BYTES * (int'(live) + 1 + int'(granted))) &&
                      !stop_now;

    // Next buffer contents: shift out eaten halfwords, then append the beat.
    always_comb begin
        buf_nxt   = buf_hw;
        tag_nxt   = buf_tag;
        depth_nxt = depth;
        if (cf_evt) begin
            depth_nxt = '0;
        end else begin
            for (int i = 0; i < NH; i++) begin
                if (i + int'(eat_bytes >> 1) < NH) begin
                    buf_nxt[i] = buf_hw[HIW'(i + int'(eat_bytes >> 1))];
                    tag_nxt[i] = buf_tag[HIW'(i + int'(eat_bytes >> 1))];
                end
            end
            if (append) begin
                for (int k = 0; k < FH; k++) begin
                    if ((k >= int'(skip >> 1)) &&
                        (int'(base_b >> 1) + k - int'(skip >> 1) < NH)) begin
                        buf_nxt[HIW'(int'(base_b >> 1) + k - int'(skip >> 1))] =
                            imem.imem_rsp_rdata[16*k +: 16];
                        tag_nxt[HIW'(int'(base_b >> 1) + k - int'(skip >> 1))] =
                            imem.imem_rsp_err;
                    end
                end
            end
            depth_nxt = base_b + (append ? (DW'(FETCH_BYTES) - DW'(skip)) : DW'(0));
        end
    end

    // Register buffer, PC, address phase and in-flight accounting.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            buf_hw         <= '{default: '0};
            buf_tag        <= '0;
            depth          <= '0;
            outstanding    <= '0;
            drop_cnt       <= '0;
            skip           <= RESET_SKIP;
            s1_pc          <= PC_RESET_ADDRESS;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= PC_RESET_ADDRESS & ADDR_MASK;
        end else begin
            buf_hw      <= buf_nxt;
            buf_tag     <= tag_nxt;
            depth       <= depth_nxt;
            outstanding <= os_nxt;
            if (cf_evt) begin
                // Everything still in flight after this edge is stale.
                drop_cnt       <= os_nxt;
                skip           <= cf_target[SW-1:0] & ~SW'(1);
                s1_pc          <= cf_target & ~XLEN'(1);
                imem.imem_addr <= cf_target & ADDR_MASK;
                imem.imem_req  <= (int'(os_nxt) < MAX_OUTSTANDING);
            end else begin
                if (imem.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
                if (append) skip <= '0;
                s1_pc <= s1_pc + XLEN'(eat_bytes);
                if (granted) imem.imem_addr <= imem.imem_addr + XLEN'(FETCH_BYTES);
                if (!(imem.imem_req && !imem.imem_gnt)) imem.imem_req <= issue_ok;
            end
        end
    end

    a_eat_both: assert property (@(posedge g_clk) disable iff (!g_resetn)
        !(s2_eat_2 && s2_eat_4));
    a_eat4_depth: assert property (@(posedge g_clk) disable iff (!g_resetn)
        s2_eat_4 |-> (depth >= DW'(4)));
    a_rsp_no_req: assert property (@(posedge g_clk) disable iff (!g_resetn)
        imem.imem_rsp_valid |-> (outstanding != '0));
endmodule

// File: tb/tb_core_pipe_fetch_pf.sv
module tb_core_pipe_fetch_pf;
    localparam int XLEN = 64, FB = 8, BUFB = 16, MAXO = 2, NCYC = 6000;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        g_clk = 1'b0, g_resetn = 1'b0;
    logic        cf_valid, cf_ack, s1_valid, s2_eat_2, s2_eat_4;
    logic [63:0] cf_target, s1_pc;
    logic [31:0] s1_instr;
    logic [1:0]  s1_ferr;

    always #5 g_clk = ~g_clk;

    core_pipe_fetch_pf_if #(.XLEN(XLEN), .FETCH_BYTES(FB)) imem_bus ();

    core_pipe_fetch_pf #(.XLEN(XLEN), .FETCH_BYTES(FB), .BUF_BYTES(BUFB),
                         .MAX_OUTSTANDING(MAXO), .PC_RESET_ADDRESS(RST_PC)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .cf_valid(cf_valid), .cf_ack(cf_ack),
        .cf_target(cf_target), .imem(imem_bus), .s1_valid(s1_valid), .s1_instr(s1_instr),
        .s1_pc(s1_pc), .s1_ferr(s1_ferr), .s2_eat_2(s2_eat_2), .s2_eat_4(s2_eat_4));

    int checks = 0, errors = 0, pops = 0;
    bit run = 0;
    int unsigned salt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory image: a pseudo-random byte per address, biased so roughly half
    // of the halfwords open a 32-bit instruction.
    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [31:0] h;
        logic [7:0]  b;
        h = (a[31:0] * 32'h9E37_79B1) ^ salt;
        h = h ^ (h >> 15);
        b = h[7:0];
        if (!a[0] && h[9]) b[1:0] = 2'b11;
        return b;
    endfunction

    function automatic logic err_beat(input logic [63:0] a);
        logic [31:0] h;
        h = ((a[31:0] & ~32'd7) * 32'h85EB_CA6B) ^ salt;
        return (h[27:24] == 4'd0);
    endfunction

    typedef struct { logic [63:0] pc; logic [31:0] instr; int len; logic [1:0] ferr; } exp_t;
    exp_t sb[$];

    function automatic exp_t model_at(input logic [63:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = {mem_byte(pc + 3), mem_byte(pc + 2), mem_byte(pc + 1), mem_byte(pc)};
        e.ferr  = {err_beat(pc + 2), err_beat(pc)};
        e.len   = (e.instr[1:0] == 2'b11 && !e.ferr[0]) ? 4 : 2;
        return e;
    endfunction

    task automatic push_stream(input logic [63:0] start);
        logic [63:0] pc;
        exp_t e;
        pc = start & ~64'd1;
        for (int n = 0; n < 80; n++) begin
            e = model_at(pc);
            sb.push_back(e);
            pc = pc + 64'(e.len);
        end
    endtask

    typedef struct { logic [63:0] addr; int due; int gen; } req_t;

    // Stimulus: memory, control-flow changes and decode eats.
    initial begin
        req_t pend[$];
        req_t r;
        bit   responded, fire_pend, stopped;
        int   gen, since_cf, n_out, grants_after_stop;
        salt = $urandom;
        cf_valid = 0; cf_target = '0; s2_eat_2 = 0; s2_eat_4 = 0;
        imem_bus.imem_gnt = 0; imem_bus.imem_rsp_valid = 0;
        imem_bus.imem_rsp_err = 0; imem_bus.imem_rsp_rdata = '0;
        gen = 0; since_cf = 0; fire_pend = 0; stopped = 0; grants_after_stop = 0;
        repeat (3) @(posedge g_clk);
        #1;
        check("rst_req", {63'd0, imem_bus.imem_req}, 64'd0);
        check("rst_addr", imem_bus.imem_addr, RST_PC & ~64'd7);
        check("rst_valid", {63'd0, s1_valid}, 64'd0);
        check("rst_pc", s1_pc, RST_PC);
        g_resetn = 1;
        push_stream(RST_PC);
        run = 1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge g_clk);
            #1;
            if (cyc == 0) begin
                check("first_req", {63'd0, imem_bus.imem_req}, 64'd1);
                check("first_addr", imem_bus.imem_addr, RST_PC);
            end
            if (fire_pend) begin
                sb.delete();
                push_stream(cf_target);
                gen++;
                cf_valid = 0; since_cf = 0; stopped = 0; grants_after_stop = 0;
            end
            n_out = pend.size();
            imem_bus.imem_rsp_valid = 0;
            responded = 0;
            if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 3) != 0) begin
                r = pend.pop_front();
                responded = 1;
                imem_bus.imem_rsp_valid = 1;
                imem_bus.imem_rsp_err = err_beat(r.addr);
                for (int k = 0; k < FB; k++) imem_bus.imem_rsp_rdata[8*k +: 8] = mem_byte(r.addr + 64'(k));
            end
            imem_bus.imem_gnt = ($urandom_range(0, 9) < 6);
            if (imem_bus.imem_req && imem_bus.imem_gnt) begin
                check("outstanding_limit", 64'(n_out < MAXO), 64'd1);
                pend.push_back('{imem_bus.imem_addr, cyc + int'($urandom_range(1, 3)), gen});
`ifdef CORE_FETCH_ERR_STOP_EN
                if (stopped) begin
                    grants_after_stop++;
                    check("err_stop_grants", 64'(grants_after_stop <= 1), 64'd1);
                end
`endif
            end
            if (!cf_valid && (since_cf > 45 || $urandom_range(0, 39) == 0)) begin
                cf_valid = 1;
                cf_target = RST_PC + 64'($urandom_range(0, 4095));
            end
            fire_pend = cf_valid && (!imem_bus.imem_req || imem_bus.imem_gnt);
            if (responded && r.gen == gen && !fire_pend && imem_bus.imem_rsp_err) stopped = 1;
            s2_eat_2 = 0; s2_eat_4 = 0;
            if (s1_valid && $urandom_range(0, 4) != 0) begin
                if (s1_instr[1:0] == 2'b11 && !s1_ferr[0]) s2_eat_4 = 1;
                else s2_eat_2 = 1;
            end
            since_cf++;
        end
        @(negedge g_clk);
        run = 0;
        check("throughput", 64'(pops >= 100), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Monitor: protocol rules and scoreboard comparison of consumed instructions.
    logic        prev_stall = 0, prev_fire = 0;
    logic [63:0] prev_addr = '0, prev_tgt = '0;
    always @(negedge g_clk) begin
        exp_t e;
        logic fire;
        if (run) begin
            check("cf_ack", {63'd0, cf_ack}, {63'd0, !imem_bus.imem_req || imem_bus.imem_gnt});
            if (prev_stall) begin
                check("hold_req", {63'd0, imem_bus.imem_req}, 64'd1);
                check("hold_addr", imem_bus.imem_addr, prev_addr);
            end
            if (prev_fire) begin
                check("cf_addr", imem_bus.imem_addr, prev_tgt & ~64'd7);
                check("cf_flush", {63'd0, s1_valid}, 64'd0);
                check("cf_pc", s1_pc, prev_tgt & ~64'd1);
            end
            if (imem_bus.imem_req) check("addr_align", {61'd0, imem_bus.imem_addr[2:0]}, 64'd0);
            fire = cf_valid && cf_ack;
            if (!fire && s1_valid && (s2_eat_2 || s2_eat_4)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got consumed pc %h expected none", s1_pc);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    check("pc", s1_pc, e.pc);
                    check("instr_lo", {48'd0, s1_instr[15:0]}, {48'd0, e.instr[15:0]});
                    check("ferr_lo", {63'd0, s1_ferr[0]}, {63'd0, e.ferr[0]});
                    check("len", s2_eat_4 ? 64'd4 : 64'd2, 64'(e.len));
                    if (e.len == 4) begin
                        check("instr_hi", {48'd0, s1_instr[31:16]}, {48'd0, e.instr[31:16]});
                        check("ferr_hi", {63'd0, s1_ferr[1]}, {63'd0, e.ferr[1]});
                    end
                end
            end
            prev_stall = imem_bus.imem_req && !imem_bus.imem_gnt;
            prev_addr  = imem_bus.imem_addr;
            prev_fire  = fire;
            prev_tgt   = cf_target;
        end
    end
endmodule
